// File: rtl/nand_io_burst_pkg.sv
// nand_io_pkg: state encoding, transfer direction and default timing for the
// NAND burst IO unit.
package nand_io_pkg;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_WAIT,
    IO_STROBE,
    IO_HOLD
  } io_state_t;

  localparam logic IO_WRITE = 1'b0;
  localparam logic IO_READ  = 1'b1;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_TW     = 8;
  localparam int unsigned DEF_T_WP   = 2;
  localparam int unsigned DEF_T_WH   = 2;
  localparam int unsigned DEF_T_REA  = 3;
  localparam int unsigned DEF_T_REH  = 2;

endpackage

// File: rtl/nand_io_burst_if.sv
// nand_io_burst_if: sequencer/datapath handshake and DQ pad signals of the
// burst IO unit. The tim_cfg field exists only when NAND_IO_RUNTIME_TIMING_EN
// is defined.
interface nand_io_burst_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
`ifdef NAND_IO_RUNTIME_TIMING_EN
  , parameter int unsigned TW   = 8
`endif
);

  logic              start;
  logic              dir;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] io_din;
  logic [DATA_W-1:0] io_dout;
  logic              io_oe;
  logic              io_ctrl;
  logic              busy;
  logic              done;
`ifdef NAND_IO_RUNTIME_TIMING_EN
  logic [4*TW-1:0]   tim_cfg;

  modport master (
    output start, dir, count, wr_data, wr_valid, io_din, tim_cfg,
    input  wr_ready, rd_data, rd_valid, io_dout, io_oe, io_ctrl, busy, done
  );

  modport slave (
    input  start, dir, count, wr_data, wr_valid, io_din, tim_cfg,
    output wr_ready, rd_data, rd_valid, io_dout, io_oe, io_ctrl, busy, done
  );
`else
  modport master (
    output start, dir, count, wr_data, wr_valid, io_din,
    input  wr_ready, rd_data, rd_valid, io_dout, io_oe, io_ctrl, busy, done
  );

  modport slave (
    input  start, dir, count, wr_data, wr_valid, io_din,
    output wr_ready, rd_data, rd_valid, io_dout, io_oe, io_ctrl, busy, done
  );
`endif

endinterface

// File: rtl/nand_io_burst_timer.sv
// nand_io_timer: loadable down-counter used for every strobe/hold phase.
// A phase of T cycles is obtained by loading T-1; expired is high at zero.
module nand_io_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_expired
);

  logic [TW-1:0] r_cnt;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/nand_io_burst.sv
// nand_io_burst: multi-word burst engine between the NAND command sequencer
// and the DQ pads. Generates WE#/RE# on io_ctrl with configurable strobe-low
// and strobe-high times and supports write back-pressure via wr_valid.
// Optional feature macro: NAND_IO_RUNTIME_TIMING_EN (adds bus.tim_cfg,
// packed {T_REH, T_REA, T_WH, T_WP}, sampled when a burst is accepted).
module nand_io_burst
  import nand_io_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned TW     = DEF_TW,
  parameter int unsigned T_WP   = DEF_T_WP,
  parameter int unsigned T_WH   = DEF_T_WH,
  parameter int unsigned T_REA  = DEF_T_REA,
  parameter int unsigned T_REH  = DEF_T_REH
) (
  input  logic             clk,
  input  logic             reset,
  nand_io_burst_if.slave   bus
);

  io_state_t         r_state;
  logic              r_dir;
  logic [CNT_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_io_dout;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_io_oe;
  logic              r_io_ctrl;
  logic              r_busy;
  logic              r_done;

  // Timing offered with the start request, and timing in force for the burst.
  logic [TW-1:0]     w_cfg_wp, w_cfg_wh, w_cfg_rea, w_cfg_reh;
  logic [TW-1:0]     w_t_wp, w_t_wh, w_t_rea, w_t_reh;

  logic              w_start_ok;
  logic              w_word_ok;
  logic              w_strobe_end;
  logic              w_hold_end;
  logic              w_more;
  logic              w_tmr_exp;
  logic              w_tmr_load;
  logic [TW-1:0]     w_tmr_val;

`ifdef NAND_IO_RUNTIME_TIMING_EN
  logic [TW-1:0]     r_t_wp, r_t_wh, r_t_rea, r_t_reh;

  function automatic logic [TW-1:0] at_least_one(input logic [TW-1:0] v);
    return (v == '0) ? TW'(1) : v;
  endfunction

  assign w_cfg_wp  = at_least_one(bus.tim_cfg[0*TW +: TW]);
  assign w_cfg_wh  = at_least_one(bus.tim_cfg[1*TW +: TW]);
  assign w_cfg_rea = at_least_one(bus.tim_cfg[2*TW +: TW]);
  assign w_cfg_reh = at_least_one(bus.tim_cfg[3*TW +: TW]);

  // Freeze the runtime timing at burst acceptance for the whole burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_t_wp  <= TW'(T_WP);
      r_t_wh  <= TW'(T_WH);
      r_t_rea <= TW'(T_REA);
      r_t_reh <= TW'(T_REH);
    end else if (w_start_ok) begin
      r_t_wp  <= w_cfg_wp;
      r_t_wh  <= w_cfg_wh;
      r_t_rea <= w_cfg_rea;
      r_t_reh <= w_cfg_reh;
    end
  end

  assign w_t_wp  = r_t_wp;
  assign w_t_wh  = r_t_wh;
  assign w_t_rea = r_t_rea;
  assign w_t_reh = r_t_reh;
`else
  assign w_cfg_wp  = TW'(T_WP);
  assign w_cfg_wh  = TW'(T_WH);
  assign w_cfg_rea = TW'(T_REA);
  assign w_cfg_reh = TW'(T_REH);

  assign w_t_wp  = w_cfg_wp;
  assign w_t_wh  = w_cfg_wh;
  assign w_t_rea = w_cfg_rea;
  assign w_t_reh = w_cfg_reh;
`endif

  assign w_start_ok   = (r_state == IO_IDLE) && bus.start && (bus.count != '0);
  assign w_word_ok    = (r_state == IO_WAIT) && bus.wr_valid;
  assign w_strobe_end = (r_state == IO_STROBE) && w_tmr_exp;
  assign w_hold_end   = (r_state == IO_HOLD) && w_tmr_exp;
  assign w_more       = (r_remaining != '0);

  // Select the phase length to load on every phase entry; the read-start
  // case must use the offered timing because the frozen copy is not yet valid.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if (w_start_ok && (bus.dir == IO_READ)) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = w_cfg_rea - TW'(1);
    end else if (w_word_ok) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = w_t_wp - TW'(1);
    end else if (w_strobe_end) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = (r_dir == IO_READ) ? (w_t_reh - TW'(1)) : (w_t_wh - TW'(1));
    end else if (w_hold_end && w_more && (r_dir == IO_READ)) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = w_t_rea - TW'(1);
    end
  end

  nand_io_timer #(
    .TW (TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_tmr_exp)
  );

  // Burst sequencer with registered strobe, drive-enable and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IO_IDLE;
      r_dir       <= IO_WRITE;
      r_remaining <= '0;
      r_io_dout   <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_io_oe     <= 1'b0;
      r_io_ctrl   <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IO_IDLE: begin
          if (w_start_ok) begin
            r_dir       <= bus.dir;
            r_remaining <= bus.count;
            r_busy      <= 1'b1;
            if (bus.dir == IO_READ) begin
              r_state   <= IO_STROBE;
              r_io_ctrl <= 1'b0;
            end else begin
              r_state   <= IO_WAIT;
              r_io_oe   <= 1'b1;
            end
          end
        end
        IO_WAIT: begin
          if (bus.wr_valid) begin
            r_io_dout <= bus.wr_data;
            r_io_ctrl <= 1'b0;
            r_state   <= IO_STROBE;
          end
        end
        IO_STROBE: begin
          if (w_tmr_exp) begin
            r_state   <= IO_HOLD;
            r_io_ctrl <= 1'b1;
            if (r_remaining != '0) begin
              r_remaining <= r_remaining - CNT_W'(1);
            end
            if (r_dir == IO_READ) begin
              r_rd_data  <= bus.io_din;
              r_rd_valid <= 1'b1;
            end
          end
        end
        IO_HOLD: begin
          if (w_tmr_exp) begin
            if (!w_more) begin
              r_state <= IO_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_io_oe <= 1'b0;
            end else if (r_dir == IO_READ) begin
              r_state   <= IO_STROBE;
              r_io_ctrl <= 1'b0;
            end else begin
              r_state <= IO_WAIT;
            end
          end
        end
        default: r_state <= IO_IDLE;
      endcase
    end
  end

  // wr_ready is decoded from the WAIT state so the strobe falls exactly one
  // cycle after the accepting handshake.
  assign bus.wr_ready = (r_state == IO_WAIT) && bus.wr_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.io_dout  = r_io_dout;
  assign bus.io_oe    = r_io_oe;
  assign bus.io_ctrl  = r_io_ctrl;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_nand_io_burst.sv
// tb_nand_io_burst: table of bursts plus hand-written corner sequences; a
// cycle-accurate timing model fills event queues that a negedge monitor pops.
module tb_nand_io_burst;
  import nand_io_pkg::*;

  typedef struct {
    int unsigned cyc;
    logic [15:0] data;
    logic        chk;
  } ev_t;

  typedef struct {
    logic        dir;
    int unsigned count;
    int unsigned stall;
    bit          poke;
    int unsigned exp_total;
  } vec_t;

  logic        clk;
  logic        reset;
  int unsigned cyc = 0;

  int checks   = 0;
  int failures = 0;

  ev_t         acc_q[$];
  ev_t         stb_q[$];
  ev_t         rd_q[$];
  int unsigned done_q[$];

  logic [15:0] wdata [4];
  int unsigned widx      = 0;
  bit          done_seen = 0;
  bit          busy_seen = 0;
  bit          ign_len   = 0;
  int unsigned oe_err    = 0;
  logic        cur_dir   = IO_WRITE;
  int unsigned cur_lo    = 2;
  int unsigned fall_cyc  = 0;
  logic        prev_ctrl = 1'b1;

  int unsigned m_twp  = 2;
  int unsigned m_twh  = 2;
  int unsigned m_trea = 3;
  int unsigned m_treh = 2;

  vec_t vecs [7];

`ifdef NAND_IO_RUNTIME_TIMING_EN
  nand_io_burst_if #(.DATA_W(16), .CNT_W(16), .TW(8)) bus ();
`else
  nand_io_burst_if #(.DATA_W(16), .CNT_W(16)) bus ();
`endif

  nand_io_burst #(
    .DATA_W (16),
    .CNT_W  (16),
    .TW     (8),
    .T_WP   (2),
    .T_WH   (2),
    .T_REA  (3),
    .T_REH  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [15:0] din_f(input int unsigned n);
    return 16'(n) ^ 16'hC3C3;
  endfunction

  assign bus.io_din = din_f(cyc);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected pulse at cycle %0d expected none", name, cyc);
  endtask

  // Monitor: pop expected events as the DUT produces them.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (bus.busy) busy_seen = 1'b1;
      if (bus.busy && (bus.io_oe !== (cur_dir == IO_WRITE))) oe_err++;
      if (bus.wr_ready) begin
        if (acc_q.size() == 0) unexpected("wr_ready");
        else begin
          e = acc_q.pop_front();
          check("wr_ready_cyc", cyc, e.cyc);
        end
        widx++;
      end
      if (!bus.io_ctrl && prev_ctrl) begin
        fall_cyc = cyc;
        if (stb_q.size() == 0) unexpected("strobe");
        else begin
          e = stb_q.pop_front();
          check("strobe_cyc", cyc, e.cyc);
          if (e.chk) check("io_dout", bus.io_dout, e.data);
        end
      end
      if (bus.io_ctrl && !prev_ctrl && !ign_len) check("strobe_low", cyc - fall_cyc, cur_lo);
      if (bus.rd_valid) begin
        if (rd_q.size() == 0) unexpected("rd_valid");
        else begin
          e = rd_q.pop_front();
          check("rd_valid_cyc", cyc, e.cyc);
          check("rd_data", bus.rd_data, e.data);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) unexpected("done");
        else check("done_cyc", cyc, done_q.pop_front());
        check("done_busy", bus.busy, 0);
        done_seen = 1'b1;
      end
    end
    prev_ctrl = bus.io_ctrl;
  end

  task automatic run_burst(input logic d, input int unsigned n, input int unsigned stall,
                           input bit poke, input int unsigned exp_total, input int unsigned abort_at);
    int unsigned s, p, w;
    bit aborted;
    aborted   = 1'b0;
    widx      = 0;
    done_seen = 1'b0;
    oe_err    = 0;
    cur_dir   = d;
    cur_lo    = (d == IO_READ) ? m_trea : m_twp;
    bus.dir      = d;
    bus.count    = 16'(n);
    bus.start    = 1'b1;
    bus.wr_valid = 1'b0;
    tick();
    s = cyc;
    bus.start = 1'b0;
    bus.dir   = ~d;
    bus.count = 16'd7;
    p = (d == IO_WRITE) ? (1 + m_twp + m_twh) : (m_trea + m_treh);
    for (int unsigned k = 0; k < n; k++) begin
      if (d == IO_WRITE) begin
        w = s + k * p + ((k >= 1) ? stall : 0);
        acc_q.push_back('{cyc: w, data: 16'h0, chk: 1'b0});
        stb_q.push_back('{cyc: w + 1, data: wdata[k % 4], chk: 1'b1});
      end else begin
        stb_q.push_back('{cyc: s + k * p, data: 16'h0, chk: 1'b0});
        rd_q.push_back('{cyc: s + m_trea + k * p, data: din_f(s + m_trea - 1 + k * p), chk: 1'b1});
      end
    end
    if (abort_at == 0) done_q.push_back(s + exp_total);
    for (int unsigned c = 0; c < 400 && !done_seen && !aborted; c++) begin
      bus.wr_valid = (d == IO_WRITE) && !(stall != 0 && cyc >= s + p && cyc < s + p + stall);
      bus.wr_data  = wdata[widx % 4];
      bus.start    = poke && (cyc == s + 4);
      if (poke && (cyc == s + 4)) begin
        bus.count = 16'd1;
        bus.dir   = ~d;
      end
      if (abort_at != 0 && cyc == s + abort_at) begin
        reset   = 1'b1;
        ign_len = 1'b1;
      end
      tick();
      if (reset) begin
        check("abort_io_ctrl", bus.io_ctrl, 1);
        check("abort_io_oe", bus.io_oe, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_io_dout", bus.io_dout, 0);
        reset = 1'b0;
        acc_q.delete();
        stb_q.delete();
        rd_q.delete();
        done_q.delete();
        aborted = 1'b1;
      end
    end
    bus.wr_valid = 1'b0;
    if (aborted) begin
      repeat (6) tick();
      ign_len = 1'b0;
    end else begin
      check("done_seen", done_seen, 1);
      repeat (2) tick();
      check("acc_left", acc_q.size(), 0);
      check("strobe_left", stb_q.size(), 0);
      check("rd_left", rd_q.size(), 0);
      check("io_oe_burst", oe_err, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    wdata[0] = 16'hA5A5;
    wdata[1] = 16'h1234;
    wdata[2] = 16'hFFFF;
    wdata[3] = 16'h5A5A;
    vecs[0] = '{dir: IO_WRITE, count: 3, stall: 0, poke: 1'b0, exp_total: 15};
    vecs[1] = '{dir: IO_READ,  count: 2, stall: 0, poke: 1'b0, exp_total: 10};
    vecs[2] = '{dir: IO_WRITE, count: 2, stall: 4, poke: 1'b0, exp_total: 14};
    vecs[3] = '{dir: IO_WRITE, count: 3, stall: 0, poke: 1'b1, exp_total: 15};
    vecs[4] = '{dir: IO_READ,  count: 3, stall: 0, poke: 1'b1, exp_total: 15};
    vecs[5] = '{dir: IO_WRITE, count: 1, stall: 0, poke: 1'b0, exp_total: 5};
    vecs[6] = '{dir: IO_READ,  count: 1, stall: 0, poke: 1'b0, exp_total: 5};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dir      = IO_WRITE;
    bus.count    = '0;
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;
`ifdef NAND_IO_RUNTIME_TIMING_EN
    bus.tim_cfg  = {8'd2, 8'd3, 8'd2, 8'd2};
`endif
    repeat (3) tick();
    check("rst_io_ctrl", bus.io_ctrl, 1);
    check("rst_io_oe", bus.io_oe, 0);
    check("rst_io_dout", bus.io_dout, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    repeat (2) tick();

    for (int unsigned i = 0; i < 7; i++) begin
      run_burst(vecs[i].dir, vecs[i].count, vecs[i].stall, vecs[i].poke, vecs[i].exp_total, 0);
      repeat (2) tick();
    end

    // count = 0 must leave the block idle with wr_valid offered.
    busy_seen    = 1'b0;
    bus.dir      = IO_WRITE;
    bus.count    = '0;
    bus.wr_valid = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.wr_valid = 1'b0;
    check("cnt0_busy", busy_seen, 0);
    check("cnt0_io_oe", bus.io_oe, 0);

    // Reset in the second strobe cycle of word 2 of 4, then a normal burst.
    run_burst(IO_WRITE, 4, 0, 1'b0, 0, 7);
    run_burst(IO_READ, 2, 0, 1'b0, 10, 0);
    repeat (2) tick();

`ifdef NAND_IO_RUNTIME_TIMING_EN
    m_twp  = 3;
    m_twh  = 1;
    m_trea = 4;
    m_treh = 1;
    bus.tim_cfg = {8'd1, 8'd4, 8'd0, 8'd3};
    run_burst(IO_WRITE, 2, 0, 1'b0, 10, 0);
    repeat (2) tick();
    run_burst(IO_READ, 2, 0, 1'b0, 10, 0);
    repeat (2) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
